// File: rtl/bram_tree_queue_pkg.sv
// Shared definitions for the heap-based priority queue: controller states and
// helpers that derive the tree geometry from the queue capacity.
package bram_tree_queue_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LAST_READ = 4'd1,
    LAST_WAIT = 4'd2,
    SIFT_READ = 4'd3,
    SIFT_WAIT = 4'd4,
    SIFT_CMP  = 4'd5,
    INS_READ  = 4'd6,
    INS_WAIT  = 4'd7,
    INS_CMP   = 4'd8
  } state_t;

  function automatic int num_levels(input int qsize);
    return $clog2(qsize + 1);
  endfunction

  // Widest node index needed, i.e. that of the deepest level.
  function automatic int addr_width(input int qsize);
    return (num_levels(qsize) > 2) ? num_levels(qsize) - 1 : 1;
  endfunction

  function automatic int msb_index(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_tree_queue_tree_level_bram.sv
// One heap level stored in block RAM: two registered read ports so both
// children of a node come back together, plus a single write port.
module tree_level_bram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 2
) (
  input  logic                  clk_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_a_i,
  input  logic [ADDR_W-1:0]     raddr_b_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  output logic [DATA_WIDTH-1:0] rdata_b_o
);

  logic [DATA_WIDTH-1:0] memory [2**ADDR_W];
  logic [DATA_WIDTH-1:0] rdata_a_q;
  logic [DATA_WIDTH-1:0] rdata_b_q;

  always_ff @(posedge clk_i) begin
    if (we_i) memory[waddr_i] <= wdata_i;
  end

  // Outputs hold their last value while re_i is low.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_a_q <= memory[raddr_a_i];
      rdata_b_q <= memory[raddr_b_i];
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/bram_tree_queue.sv
// Max-priority queue as a binary heap: root and level 1 in flops, deeper
// levels in block RAM, with top-down insertion and sift-down removal.
module bram_tree_queue
  import bram_tree_queue_pkg::*;
#(
  parameter int QUEUE_SIZE = 7,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  i_wrt,
  input  logic                  i_read,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int L   = num_levels(QUEUE_SIZE);
  localparam int NB  = L - 2;
  localparam int AW  = addr_width(QUEUE_SIZE);
  localparam int SW  = L;
  localparam int LVW = $clog2(L + 1);
  localparam logic [SW-1:0] FULL_CNT = SW'(QUEUE_SIZE);

  state_t                state, next_state;
  logic [SW-1:0]         queue_size, next_queue_size;
  logic [DATA_WIDTH-1:0] level_0, next_level_0;
  logic [DATA_WIDTH-1:0] level_1 [2];
  logic [DATA_WIDTH-1:0] next_level_1 [2];

  // Cursor: key being carried plus the (level, index) it currently sits at.
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic [LVW-1:0]        lvl_q, lvl_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [LVW-1:0]        tgt_q, tgt_d;
  logic [SW-1:0]         path_q, path_d;

  logic                  pw_en;
  logic [DATA_WIDTH-1:0] pw_data;
  logic                  rd_en;
  logic [LVW-1:0]        rd_lvl;
  logic [AW-1:0]         rd_addr_a, rd_addr_b;
  logic [DATA_WIDTH-1:0] rd_a [NB];
  logic [DATA_WIDTH-1:0] rd_b [NB];
  logic                  do_sift, do_ins;

  int                    ch_lvl, ch_gl, ins_m, ins_tgt, last_lvl;
  logic                  l_valid, r_valid, pick_r, swap;
  logic [DATA_WIDTH-1:0] chl, chr, big, node_rd, ins_node;
  logic [AW-1:0]         big_idx, ins_idx_nxt, ins_idx_l1, last_j;

  assign ch_lvl  = int'(lvl_q) + 1;
  assign ch_gl   = (1 << ch_lvl) - 1 + 2 * int'(idx_q);
  assign l_valid = (ch_lvl < L) && (ch_gl < int'(queue_size));
  assign r_valid = (ch_lvl < L) && (ch_gl + 1 < int'(queue_size));
  assign pick_r  = r_valid && (chr > chl);
  assign big     = pick_r ? chr : chl;
  assign big_idx = {idx_q[AW-2:0], pick_r};
  assign swap    = big > key_q;

  // Insertion path: bits of (slot+1) below its MSB, MSB-first, pick left/right.
  assign ins_m       = int'(queue_size) + 1;
  assign ins_tgt     = msb_index(ins_m);
  assign ins_idx_l1  = AW'((ins_m >> (ins_tgt - 1)) & 1);
  assign ins_idx_nxt = AW'((int'(path_q) >> (int'(tgt_q) - ch_lvl)) & ((1 << ch_lvl) - 1));
  assign ins_node    = (lvl_q == LVW'(1)) ? level_1[idx_q[0]] : node_rd;

  assign last_lvl = msb_index(int'(queue_size));
  assign last_j   = AW'(int'(queue_size) - (1 << last_lvl));

  always_comb begin
    chl     = level_1[0];
    chr     = level_1[1];
    node_rd = '0;
    for (int k = 2; k < L; k++) begin
      if (ch_lvl == k) begin
        chl = rd_a[k-2];
        chr = rd_b[k-2];
      end
      if (int'(lvl_q) == k) node_rd = rd_a[k-2];
    end
  end

  always_comb begin
    next_state      = state;
    next_queue_size = queue_size;
    next_level_0    = level_0;
    next_level_1    = level_1;
    key_d           = key_q;
    lvl_d           = lvl_q;
    idx_d           = idx_q;
    tgt_d           = tgt_q;
    path_d          = path_q;
    pw_en           = 1'b0;
    pw_data         = key_q;
    rd_en           = 1'b0;
    rd_lvl          = lvl_q;
    rd_addr_a       = idx_q;
    rd_addr_b       = idx_q;
    do_sift         = 1'b0;
    do_ins          = 1'b0;

    case (state)
      IDLE: begin
        if (i_wrt && (!i_read || queue_size == '0)) begin
          if (queue_size != FULL_CNT) begin
            next_queue_size = queue_size + 1'b1;
            if (queue_size == '0) begin
              next_level_0 = i_data;
            end else begin
              next_level_0 = (i_data > level_0) ? i_data : level_0;
              key_d        = (i_data > level_0) ? level_0 : i_data;
              path_d       = SW'(ins_m);
              tgt_d        = LVW'(ins_tgt);
              lvl_d        = LVW'(1);
              idx_d        = ins_idx_l1;
              next_state   = INS_READ;
            end
          end
        end else if (i_read && queue_size != '0) begin
          lvl_d = '0;
          idx_d = '0;
          if (i_wrt) begin
            key_d      = i_data;
            next_state = SIFT_READ;
          end else begin
            next_queue_size = queue_size - 1'b1;
            if (queue_size == SW'(1)) begin
              next_level_0 = '0;
            end else if (last_lvl == 1) begin
              key_d      = level_1[last_j[0]];
              next_state = SIFT_READ;
            end else begin
              lvl_d      = LVW'(last_lvl);
              idx_d      = last_j;
              next_state = LAST_READ;
            end
          end
        end
      end
      LAST_READ: begin
        rd_en      = 1'b1;
        next_state = LAST_WAIT;
      end
      LAST_WAIT: begin
        key_d      = node_rd;
        lvl_d      = '0;
        idx_d      = '0;
        next_state = SIFT_READ;
      end
      SIFT_READ: begin
        if (!l_valid) begin
          pw_en      = 1'b1;
          next_state = IDLE;
        end else if (ch_lvl == 1) begin
          do_sift = 1'b1;
        end else begin
          rd_en      = 1'b1;
          rd_lvl     = LVW'(ch_lvl);
          rd_addr_a  = {idx_q[AW-2:0], 1'b0};
          rd_addr_b  = {idx_q[AW-2:0], 1'b1};
          next_state = SIFT_WAIT;
        end
      end
      SIFT_WAIT: next_state = SIFT_CMP;
      SIFT_CMP:  do_sift = 1'b1;
      INS_READ: begin
        if (lvl_q == tgt_q) begin
          pw_en      = 1'b1;
          next_state = IDLE;
        end else if (lvl_q == LVW'(1)) begin
          do_ins = 1'b1;
        end else begin
          rd_en      = 1'b1;
          next_state = INS_WAIT;
        end
      end
      INS_WAIT: next_state = INS_CMP;
      INS_CMP:  do_ins = 1'b1;
      default:  next_state = IDLE;
    endcase

    // Sift step: larger child moves up on strict win, else the key settles here.
    if (do_sift) begin
      pw_en = 1'b1;
      if (swap) begin
        pw_data    = big;
        lvl_d      = LVW'(ch_lvl);
        idx_d      = big_idx;
        next_state = SIFT_READ;
      end else begin
        next_state = IDLE;
      end
    end

    if (do_ins) begin
      pw_en      = key_q > ins_node;
      key_d      = (key_q > ins_node) ? ins_node : key_q;
      lvl_d      = LVW'(ch_lvl);
      idx_d      = ins_idx_nxt;
      next_state = INS_READ;
    end

    if (pw_en && lvl_q == '0) next_level_0 = pw_data;
    if (pw_en && lvl_q == LVW'(1)) next_level_1[idx_q[0]] = pw_data;
  end

  for (genvar k = 2; k < L; k++) begin : gen_bram
    logic we, re;
    assign we = pw_en && (int'(lvl_q) == k);
    assign re = rd_en && (int'(rd_lvl) == k);

    tree_level_bram #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_W    (k)
    ) bram_inst (
      .clk_i    (CLK),
      .re_i     (re),
      .raddr_a_i(rd_addr_a[k-1:0]),
      .raddr_b_i(rd_addr_b[k-1:0]),
      .we_i     (we),
      .waddr_i  (idx_q[k-1:0]),
      .wdata_i  (pw_data),
      .rdata_a_o(rd_a[k-2]),
      .rdata_b_o(rd_b[k-2])
    );
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= IDLE;
      queue_size <= '0;
      level_0    <= '0;
      level_1[0] <= '0;
      level_1[1] <= '0;
    end else begin
      state      <= next_state;
      queue_size <= next_queue_size;
      level_0    <= next_level_0;
      level_1    <= next_level_1;
    end
  end

  always_ff @(posedge CLK) begin
    key_q  <= key_d;
    lvl_q  <= lvl_d;
    idx_q  <= idx_d;
    tgt_q  <= tgt_d;
    path_q <= path_d;
  end

  assign o_data  = level_0;
  assign o_full  = queue_size == FULL_CNT;
  assign o_empty = queue_size == '0;

endmodule

// File: tb/tb_bram_tree_queue.sv
// Bench for bram_tree_queue: directed sequences plus random traffic checked
// against an unordered multiset model whose head is its maximum element.
module tb_bram_tree_queue;

  localparam int QS = 7;
  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          i_wrt = 1'b0;
  logic          i_read = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_full, o_empty;
  logic [DW-1:0] o_data;

  int checks = 0;
  int errors = 0;
  int unsigned model[$];

  bram_tree_queue #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW)) dut (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .i_wrt  (i_wrt),
    .i_read (i_read),
    .i_data (i_data),
    .o_full (o_full),
    .o_empty(o_empty),
    .o_data (o_data)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned model_max();
    int unsigned m = 0;
    foreach (model[i]) if (model[i] > m) m = model[i];
    return m;
  endfunction

  task automatic model_pop();
    int at = 0;
    foreach (model[i]) if (model[i] > model[at]) at = i;
    model.delete(at);
  endtask

  task automatic model_apply(input bit w, input bit r, input int unsigned d);
    if (r && !w) begin
      if (model.size() > 0) model_pop();
    end else if (r && w) begin
      if (model.size() > 0) model_pop();
      model.push_back(d);
    end else if (w) begin
      if (model.size() < QS) model.push_back(d);
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".data"}, o_data, model_max());
    check_eq({tag, ".empty"}, o_empty, model.size() == 0);
    check_eq({tag, ".full"}, o_full, model.size() == QS);
  endtask

  // One strobe, then the full worst-case latency before looking at outputs.
  task automatic run_op(input bit w, input bit r, input int unsigned d);
    @(negedge CLK);
    i_wrt  = w;
    i_read = r;
    i_data = DW'(d);
    @(negedge CLK);
    i_wrt  = 1'b0;
    i_read = 1'b0;
    repeat (24) @(negedge CLK);
    model_apply(w, r, d);
  endtask

  initial begin
    int unsigned ins_keys[7] = '{5, 900, 17, 300, 42, 1024, 8};
    int unsigned ins_max[7]  = '{5, 900, 900, 900, 900, 1024, 1024};
    int unsigned deq_exp[7]  = '{900, 300, 42, 17, 8, 5, 0};
    int unsigned pre[7]      = '{1020, 800, 640, 333, 200, 90, 12};
    int unsigned rep_keys[4] = '{1, 1000, 0, 1000};
    int unsigned rep_exp[4]  = '{800, 1000, 640, 1000};

    repeat (3) @(negedge CLK);
    check_eq("rst.data", o_data, 0);
    check_eq("rst.empty", o_empty, 1);
    check_eq("rst.full", o_full, 0);
    RSTn = 1'b1;
    @(negedge CLK);

    run_op(1'b0, 1'b1, 0);
    check_state("deq_empty");

    foreach (ins_keys[i]) begin
      run_op(1'b1, 1'b0, ins_keys[i]);
      check_eq($sformatf("enq%0d.data", i), o_data, ins_max[i]);
    end
    check_eq("enq.full", o_full, 1);
    run_op(1'b1, 1'b0, 2000);
    check_eq("enq_on_full.data", o_data, 1024);
    check_state("enq_on_full");

    foreach (deq_exp[i]) begin
      run_op(1'b0, 1'b1, 0);
      check_eq($sformatf("deq%0d.data", i), o_data, deq_exp[i]);
    end
    check_eq("deq.empty", o_empty, 1);

    foreach (pre[i]) run_op(1'b1, 1'b0, pre[i]);
    check_state("preload");
    foreach (rep_keys[i]) begin
      run_op(1'b1, 1'b1, rep_keys[i]);
      check_eq($sformatf("rep%0d.data", i), o_data, rep_exp[i]);
      check_state($sformatf("rep%0d", i));
    end

    for (int n = 0; n < 100; n++) begin
      int unsigned op  = $urandom_range(0, 2);
      int unsigned key = $urandom_range(0, 1024);
      run_op(op != 0, op != 2, key);
      check_state($sformatf("rnd%0d", n));
    end

    while (model.size() < QS) run_op(1'b1, 1'b0, $urandom_range(1, 1024));
    check_state("refill");
    @(negedge CLK);
    i_read = 1'b1;
    @(negedge CLK);
    i_read = 1'b0;
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    check_eq("midrst.data", o_data, 0);
    check_eq("midrst.empty", o_empty, 1);
    check_eq("midrst.full", o_full, 0);
    @(negedge CLK);
    RSTn = 1'b1;
    model.delete();
    run_op(1'b1, 1'b0, 77);
    check_eq("post_rst.data", o_data, 77);
    check_state("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
